// File: rtl/bram_pkg.sv
// Shared constants, state encoding and helpers
// for the dual-port byte-enable block RAM.
package bram_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// LAT-deep response register chain: the first
// stage loads at the request edge.
module bram_out_pipe #(
  parameter int W   = 35,
  parameter int LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stg_q [LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < LAT; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign q_o = stg_q[LAT-1];

endmodule

// File: rtl/bram_dp_mem.sv
// True-dual-port byte-enable BRAM with clear
// sequencer, range and collision flags.
module bram_dp_mem
  import bram_pkg::*;
#(
  parameter int              DATA_W       = 32,
  parameter int              DEPTH        = 4096,
  parameter int              ADDR_W       = 32,
  parameter int              READ_LATENCY = 1,
  parameter int              WRITE_MODE   = WM_WRITE_FIRST,
  parameter logic [DATA_W-1:0] INIT_WORD  = 32'h00000000
) (
  input  logic                clkb,
  input  logic                rstb_n,
  input  logic                clear_i,
  output logic                busy_o,
  input  logic                ena,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  output logic [DATA_W-1:0]   douta,
  output logic                valida,
  output logic                erra,
  input  logic                enb,
  input  logic [DATA_W/8-1:0] web,
  input  logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   dinb,
  output logic [DATA_W-1:0]   doutb,
  output logic                validb,
  output logic                errb,
  output logic                coll_o
);

  localparam int NB    = DATA_W / 8;
  localparam int BSH   = clog2(NB);
  localparam int IDX_W = (clog2(DEPTH) > 0)
                       ? clog2(DEPTH) : 1;
  localparam int WI_W  = ADDR_W - BSH;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == ST_CLEAR);

  // a request coinciding with clear_i is dropped too
  logic go;
  assign go = !busy_o && !clear_i;

  logic [WI_W-1:0]  widx_a, widx_b;
  logic [IDX_W-1:0] ia, ib;
  logic             inr_a, inr_b;
  logic             acc_a, acc_b;
  logic             hit_a, hit_b;
  logic             wr_a, wr_b;
  logic             coll;

  assign widx_a = WI_W'(addra >> BSH);
  assign widx_b = WI_W'(addrb >> BSH);
  assign inr_a  = 64'(widx_a) < 64'(DEPTH);
  assign inr_b  = 64'(widx_b) < 64'(DEPTH);
  assign ia     = widx_a[IDX_W-1:0];
  assign ib     = widx_b[IDX_W-1:0];

  assign acc_a = ena && go;
  assign acc_b = enb && go;
  assign hit_a = acc_a && inr_a;
  assign hit_b = acc_b && inr_b;
  assign wr_a  = |wea;
  assign wr_b  = |web;

  assign coll = hit_a && hit_b && (ia == ib)
              && (wr_a || wr_b);

  logic [DATA_W-1:0] old_a, old_b;
  logic [DATA_W-1:0] mrg_a, mrg_b;
  logic [DATA_W-1:0] rsp_a, rsp_b;

  assign old_a = mem[ia];
  assign old_b = mem[ib];

  always_comb begin
    mrg_a = old_a;
    mrg_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wea[i]) mrg_a[8*i +: 8] = dina[8*i +: 8];
      if (web[i]) mrg_b[8*i +: 8] = dinb[8*i +: 8];
    end
  end

  always_comb begin
    rsp_a = '0;
    rsp_b = '0;
    if (hit_a) begin
      rsp_a = (WRITE_MODE == WM_READ_FIRST)
            ? old_a : mrg_a;
    end
    if (hit_b) begin
      rsp_b = (WRITE_MODE == WM_READ_FIRST)
            ? old_b : mrg_b;
    end
  end

  // port A writes last so it owns overlapping bytes
  always_ff @(posedge clkb) begin
    if (busy_o) begin
      mem[cnt_q] <= INIT_WORD;
    end else begin
      if (hit_b) begin
        for (int i = 0; i < NB; i++) begin
          if (web[i]) mem[ib][8*i +: 8] <= dinb[8*i +: 8];
        end
      end
      if (hit_a) begin
        for (int i = 0; i < NB; i++) begin
          if (wea[i]) mem[ia][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

  logic [DATA_W+2:0] pa_d, pa_q;
  logic [DATA_W+1:0] pb_d, pb_q;

  assign pa_d = {coll, acc_a && !inr_a, acc_a, rsp_a};
  assign pb_d = {acc_b && !inr_b, acc_b, rsp_b};

  bram_out_pipe #(
    .W   (DATA_W + 3),
    .LAT (READ_LATENCY)
  ) u_pipe_a (
    .clk_i  (clkb),
    .rst_ni (rstb_n),
    .d_i    (pa_d),
    .q_o    (pa_q)
  );

  bram_out_pipe #(
    .W   (DATA_W + 2),
    .LAT (READ_LATENCY)
  ) u_pipe_b (
    .clk_i  (clkb),
    .rst_ni (rstb_n),
    .d_i    (pb_d),
    .q_o    (pb_q)
  );

  assign douta  = pa_q[DATA_W-1:0];
  assign valida = pa_q[DATA_W];
  assign erra   = pa_q[DATA_W+1];
  assign coll_o = pa_q[DATA_W+2];

  assign doutb  = pb_q[DATA_W-1:0];
  assign validb = pb_q[DATA_W];
  assign errb   = pb_q[DATA_W+1];

endmodule

// File: tb/tb_bram_dp_mem.sv
// Directed bench: a WRITE_FIRST/latency-1 and a
// READ_FIRST/latency-2 instance share one stimulus.
module tb_bram_dp_mem;
  import bram_pkg::*;

  localparam int          D    = 16;
  localparam logic [31:0] INIT = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0;
  logic [31:0] addra = '0, addrb = '0;
  logic [31:0] dina = '0, dinb = '0;

  logic        wf_busy, wf_va, wf_vb, wf_ea, wf_eb, wf_coll;
  logic [31:0] wf_da, wf_db;
  logic        rf_busy, rf_va, rf_vb, rf_ea, rf_eb, rf_coll;
  logic [31:0] rf_da, rf_db;

  typedef struct {
    logic [31:0] da, db;
    logic        va, vb, ea, eb, coll;
  } rsp_t;

  rsp_t cw, cr;
  int   vec = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  bram_dp_mem #(
    .DATA_W(32), .DEPTH(D), .ADDR_W(32),
    .READ_LATENCY(1), .WRITE_MODE(WM_WRITE_FIRST),
    .INIT_WORD(INIT)
  ) u_wf (
    .clkb(clk), .rstb_n(rst_n), .clear_i(clr),
    .busy_o(wf_busy),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(wf_da), .valida(wf_va), .erra(wf_ea),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(wf_db), .validb(wf_vb), .errb(wf_eb),
    .coll_o(wf_coll)
  );

  bram_dp_mem #(
    .DATA_W(32), .DEPTH(D), .ADDR_W(32),
    .READ_LATENCY(2), .WRITE_MODE(WM_READ_FIRST),
    .INIT_WORD(INIT)
  ) u_rf (
    .clkb(clk), .rstb_n(rst_n), .clear_i(clr),
    .busy_o(rf_busy),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(rf_da), .valida(rf_va), .erra(rf_ea),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(rf_db), .validb(rf_vb), .errb(rf_eb),
    .coll_o(rf_coll)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0;
    wea = '0;   web = '0;
    clr = 1'b0;
  endtask

  task automatic xfer(
    input logic        ea_, input logic [3:0] wa_,
    input logic [31:0] aa_, input logic [31:0] da_,
    input logic        eb_, input logic [3:0] wb_,
    input logic [31:0] ab_, input logic [31:0] db_);
    ena = ea_; wea = wa_; addra = aa_; dina = da_;
    enb = eb_; web = wb_; addrb = ab_; dinb = db_;
    cyc();
    idle();
    cw.da = wf_da; cw.db = wf_db; cw.va = wf_va;
    cw.vb = wf_vb; cw.ea = wf_ea; cw.eb = wf_eb;
    cw.coll = wf_coll;
    cyc();
    cr.da = rf_da; cr.db = rf_db; cr.va = rf_va;
    cr.vb = rf_vb; cr.ea = rf_ea; cr.eb = rf_eb;
    cr.coll = rf_coll;
  endtask

  task automatic test_reset();
    int n;
    logic seen;
    rst_n = 1'b0;
    ena = 1'b1; addra = 32'h0;
    repeat (3) cyc();
    vec++;
    if ({wf_busy, rf_busy, wf_va, rf_va, wf_coll, rf_coll,
         wf_da, rf_db} !== {2'b11, 4'b0000, 64'h0}) begin
      miss++;
      $display("FAIL reset_vals got %h want %h",
        {wf_busy, rf_busy, wf_va, rf_va, wf_coll, rf_coll,
         wf_da, rf_db}, {2'b11, 4'b0000, 64'h0});
    end
    rst_n = 1'b1;
    n = 0; seen = 1'b0;
    while (wf_busy && n < 100) begin
      cyc();
      n++;
      if (wf_va || rf_va) seen = 1'b1;
    end
    idle();
    vec++;
    if (n !== D) begin
      miss++;
      $display("FAIL reset_busy_len got %0d want %0d", n, D);
    end
    vec++;
    if ({seen, rf_busy} !== 2'b00) begin
      miss++;
      $display("FAIL reset_drop got %b want 00", {seen, rf_busy});
    end
    for (int i = 0; i < D; i++) begin
      xfer(1'b1, 4'h0, 32'(i * 4), 32'h0,
           1'b1, 4'h0, 32'(i * 4), 32'h0);
      vec++;
      if ({cw.va, cw.da, cr.vb, cr.db} !==
          {1'b1, INIT, 1'b1, INIT}) begin
        miss++;
        $display("FAIL reset_init[%0d] got %h want %h", i,
          {cw.va, cw.da, cr.vb, cr.db},
          {1'b1, INIT, 1'b1, INIT});
      end
    end
  endtask

  task automatic test_byte_write();
    xfer(1'b1, 4'hF, 32'hC, 32'h11223344,
         1'b0, 4'h0, 32'h0, 32'h0);
    xfer(1'b1, 4'b0101, 32'hC, 32'hAABBCCDD,
         1'b0, 4'h0, 32'h0, 32'h0);
    vec++;
    if ({cw.va, cw.ea, cw.da} !== {2'b10, 32'h11BB33DD}) begin
      miss++;
      $display("FAIL bw_wf_rsp got %h want %h",
        {cw.va, cw.ea, cw.da}, {2'b10, 32'h11BB33DD});
    end
    vec++;
    if ({cr.va, cr.ea, cr.da} !== {2'b10, 32'h11223344}) begin
      miss++;
      $display("FAIL bw_rf_rsp got %h want %h",
        {cr.va, cr.ea, cr.da}, {2'b10, 32'h11223344});
    end
    xfer(1'b0, 4'h0, 32'h0, 32'h0,
         1'b1, 4'h0, 32'hC, 32'h0);
    vec++;
    if ({cw.db, cr.db} !== {32'h11BB33DD, 32'h11BB33DD}) begin
      miss++;
      $display("FAIL bw_readback got %h want %h",
        {cw.db, cr.db}, {32'h11BB33DD, 32'h11BB33DD});
    end
  endtask

  task automatic test_back_to_back();
    ena = 1'b1; wea = 4'hF; addra = 32'h14;
    dina = 32'hDEADBEEF;
    enb = 1'b1; web = 4'h0; addrb = 32'hC;
    cyc();
    vec++;
    if ({wf_va, wf_da, wf_vb, wf_db, rf_va} !==
        {1'b1, 32'hDEADBEEF, 1'b1, 32'h11BB33DD, 1'b0}) begin
      miss++;
      $display("FAIL b2b_c1 got %h want %h",
        {wf_va, wf_da, wf_vb, wf_db, rf_va},
        {1'b1, 32'hDEADBEEF, 1'b1, 32'h11BB33DD, 1'b0});
    end
    wea = 4'h0;
    cyc();
    idle();
    vec++;
    if ({wf_va, wf_da, rf_va, rf_da} !==
        {1'b1, 32'hDEADBEEF, 1'b1, INIT}) begin
      miss++;
      $display("FAIL b2b_c2 got %h want %h",
        {wf_va, wf_da, rf_va, rf_da},
        {1'b1, 32'hDEADBEEF, 1'b1, INIT});
    end
    cyc();
    vec++;
    if ({rf_va, rf_da, rf_vb, rf_db} !==
        {1'b1, 32'hDEADBEEF, 1'b1, 32'h11BB33DD}) begin
      miss++;
      $display("FAIL b2b_c3 got %h want %h",
        {rf_va, rf_da, rf_vb, rf_db},
        {1'b1, 32'hDEADBEEF, 1'b1, 32'h11BB33DD});
    end
  endtask

  task automatic test_collision();
    xfer(1'b1, 4'hF, 32'h1C, 32'h0,
         1'b0, 4'h0, 32'h0, 32'h0);
    xfer(1'b1, 4'b0001, 32'h1C, 32'h000000FF,
         1'b1, 4'b0011, 32'h1C, 32'h0000FF00);
    vec++;
    if ({cw.coll, cr.coll} !== 2'b11) begin
      miss++;
      $display("FAIL coll_flag got %b want 11",
        {cw.coll, cr.coll});
    end
    xfer(1'b1, 4'h0, 32'h1C, 32'h0,
         1'b0, 4'h0, 32'h0, 32'h0);
    vec++;
    if ({cw.coll, cw.da, cr.coll, cr.da} !==
        {1'b0, 32'h0000FFFF, 1'b0, 32'h0000FFFF}) begin
      miss++;
      $display("FAIL coll_merge got %h want %h",
        {cw.coll, cw.da, cr.coll, cr.da},
        {1'b0, 32'h0000FFFF, 1'b0, 32'h0000FFFF});
    end
    xfer(1'b1, 4'h0, 32'h1C, 32'h0,
         1'b1, 4'hF, 32'h1C, 32'h12345678);
    vec++;
    if ({cw.coll, cw.da, cr.coll, cr.da} !==
        {1'b1, 32'h0000FFFF, 1'b1, 32'h0000FFFF}) begin
      miss++;
      $display("FAIL coll_rd_old got %h want %h",
        {cw.coll, cw.da, cr.coll, cr.da},
        {1'b1, 32'h0000FFFF, 1'b1, 32'h0000FFFF});
    end
    xfer(1'b1, 4'hF, 32'h20, 32'hA5A5A5A5,
         1'b1, 4'hF, 32'h24, 32'h5A5A5A5A);
    vec++;
    if ({cw.coll, cr.coll} !== 2'b00) begin
      miss++;
      $display("FAIL coll_disjoint got %b want 00",
        {cw.coll, cr.coll});
    end
    xfer(1'b1, 4'h0, 32'h20, 32'h0,
         1'b1, 4'h0, 32'h1C, 32'h0);
    vec++;
    if ({cw.da, cr.db} !== {32'hA5A5A5A5, 32'h12345678}) begin
      miss++;
      $display("FAIL coll_after got %h want %h",
        {cw.da, cr.db}, {32'hA5A5A5A5, 32'h12345678});
    end
  endtask

  task automatic test_out_of_range();
    xfer(1'b0, 4'h0, 32'h0, 32'h0,
         1'b1, 4'h0, 32'(D * 4), 32'h0);
    vec++;
    if ({cw.vb, cw.eb, cw.db, cr.vb, cr.eb, cr.db} !==
        {2'b11, 32'h0, 2'b11, 32'h0}) begin
      miss++;
      $display("FAIL oor_read got %h want %h",
        {cw.vb, cw.eb, cw.db, cr.vb, cr.eb, cr.db},
        {2'b11, 32'h0, 2'b11, 32'h0});
    end
    xfer(1'b0, 4'h0, 32'h0, 32'h0,
         1'b1, 4'hF, 32'(D * 4), 32'hCAFEBABE);
    vec++;
    if ({cw.eb, cw.db, cr.eb} !== {1'b1, 32'h0, 1'b1}) begin
      miss++;
      $display("FAIL oor_write got %h want %h",
        {cw.eb, cw.db, cr.eb}, {1'b1, 32'h0, 1'b1});
    end
    xfer(1'b1, 4'h0, 32'h0, 32'h0,
         1'b0, 4'h0, 32'h0, 32'h0);
    vec++;
    if ({cw.ea, cw.da, cr.ea, cr.da} !==
        {1'b0, INIT, 1'b0, INIT}) begin
      miss++;
      $display("FAIL oor_unchanged got %h want %h",
        {cw.ea, cw.da, cr.ea, cr.da},
        {1'b0, INIT, 1'b0, INIT});
    end
  endtask

  task automatic test_clear();
    int n;
    logic seen;
    logic [31:0] aw [4];
    aw[0] = 32'hC;  aw[1] = 32'h14;
    aw[2] = 32'h1C; aw[3] = 32'h20;
    clr = 1'b1; ena = 1'b1; addra = 32'hC;
    cyc();
    idle();
    vec++;
    if ({wf_busy, rf_busy, wf_va} !== 3'b110) begin
      miss++;
      $display("FAIL clr_start got %b want 110",
        {wf_busy, rf_busy, wf_va});
    end
    n = 0; seen = 1'b0;
    while (wf_busy && n < 100) begin
      cyc();
      n++;
      if (wf_va || rf_va) seen = 1'b1;
    end
    vec++;
    if ({32'(n), seen} !== {32'(D), 1'b0}) begin
      miss++;
      $display("FAIL clr_busy_len got %0d/%b want %0d/0",
        n, seen, D);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 4'h0, aw[i], 32'h0,
           1'b1, 4'h0, aw[i], 32'h0);
      vec++;
      if ({cw.da, cw.db, cr.da, cr.db} !==
          {INIT, INIT, INIT, INIT}) begin
        miss++;
        $display("FAIL clr_init[%0d] got %h want %h", i,
          {cw.da, cw.db, cr.da, cr.db},
          {INIT, INIT, INIT, INIT});
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    xfer(1'b1, 4'hF, 32'h3C, 32'h77777777,
         1'b0, 4'h0, 32'h0, 32'h0);
    clr = 1'b1;
    cyc();
    idle();
    repeat (7) cyc();
    rst_n = 1'b0;
    cyc();
    vec++;
    if ({wf_busy, wf_va, rf_va, wf_da} !==
        {3'b100, 32'h0}) begin
      miss++;
      $display("FAIL mid_rst_vals got %h want %h",
        {wf_busy, wf_va, rf_va, wf_da}, {3'b100, 32'h0});
    end
    rst_n = 1'b1;
    n = 0;
    while (wf_busy && n < 100) begin
      cyc();
      n++;
    end
    vec++;
    if ({n, rf_busy} !== {32'(D), 1'b0}) begin
      miss++;
      $display("FAIL mid_rst_len got %0d want %0d", n, D);
    end
    xfer(1'b1, 4'h0, 32'h0, 32'h0,
         1'b1, 4'h0, 32'h3C, 32'h0);
    vec++;
    if ({cw.da, cw.db, cr.da, cr.db} !==
        {INIT, INIT, INIT, INIT}) begin
      miss++;
      $display("FAIL mid_rst_init got %h want %h",
        {cw.da, cw.db, cr.da, cr.db},
        {INIT, INIT, INIT, INIT});
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_clear();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==",
      vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_dp_mem.md
# bram_dp_mem

Parametrised true-dual-port, byte-enable block RAM for the riscv32i memory subsystem. It is the next-generation replacement for the single-port data/instruction BRAM models. It adds:
- configurable word width, depth and read latency;
- a selectable write mode;
- out-of-range and cross-port collision flags;
- a hardware clear sequencer with a real busy signal.

Port A serves the core. Port B serves a loader/debug master, so memory can be preloaded or inspected while the core runs.

## Interface
- DATA_W, 32: word width in bits; multiple of 8.
- DEPTH, 4096: number of words.
- ADDR_W, 32: byte-address width.
- READ_LATENCY, 1: cycles from request to data; legal values 1 or 2.
- WRITE_MODE, WM_WRITE_FIRST: one of WM_WRITE_FIRST, WM_READ_FIRST.
- INIT_WORD, 32'h00000000: value written by the clear sweep. Use 32'h00000013 for instruction memory.
- clkb  in  1  single clock, both ports.
- rstb_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  one-cycle pulse; starts a clear sweep.
- busy_o  out  1  high while the clear sweep runs; reset value 1.
- ena / enb  in  1  port request strobe.
- wea / web  in  DATA_W/8  byte write enables; all zero means read.
- addra / addrb  in  ADDR_W  byte address; word index = addr >> log2(DATA_W/8).
- dina / dinb  in  DATA_W  write data.
- douta / doutb  out  DATA_W  read data; reset value 0.
- valida / validb  out  1  douta/doutb holds the response to the request READ_LATENCY cycles earlier; reset value 0.
- erra / errb  out  1  out-of-range flag, aligned with valid; reset value 0.
- coll_o  out  1  same-word collision flag, aligned with port A valid; reset value 0.

## Operation
- States: CLEAR and READY. Reset puts the block in CLEAR with the sweep counter at 0.
- CLEAR:
  - Each cycle, write INIT_WORD to word[counter], then increment the counter.
  - After writing word DEPTH-1, move to READY at the next edge.
  - busy_o = 1 throughout. A sweep takes exactly DEPTH cycles.
- READY:
  - clear_i moves the block to CLEAR and resets the counter to 0.
  - busy_o = 0.
- Requests while busy_o = 1 are dropped: no write, no valid, no err. This also applies to a request in the same cycle as clear_i.
- Async reset mid-sweep or mid-operation:
  - Aborts everything and clears all pipeline registers.
  - The sweep restarts from word 0.
  - Memory contents are undefined until the sweep completes.
- Write: for each byte i with we[i]=1, mem[word][8i+7:8i] <= din[8i+7:8i] at the request edge.
- Read data returned for a write request:
  - WM_WRITE_FIRST: the merged word (new bytes where enabled, old bytes elsewhere).
  - WM_READ_FIRST: the old word.
- A pure read always returns the stored word.
- Out of range (word index >= DEPTH):
  - No memory access.
  - dout = 0, err = 1 and valid = 1, all with normal latency.
- Collision: both ports enabled, same in-range word, and at least one port writing.
  - Overlapping bytes written by both ports take port A's value; other enabled bytes from either port are written normally.
  - A reading port sees the pre-edge word.
  - coll_o pulses once.
- Address bits below the word index are ignored. Misaligned accesses are the master's responsibility.

## Timing
- READY is entered DEPTH cycles after rstb_n rises, or DEPTH cycles after the clear_i edge.
- READ_LATENCY=1: dout, valid and err are registered at the request edge, visible the following cycle.
- READ_LATENCY=2: one extra output register stage. valid, err and coll_o are delayed identically.
- Back-to-back requests on both ports are accepted every cycle; there is no stall.
- Write data lands in the array at the request edge. A read of the same word on the next cycle returns the new data.

## Structure
- Package bram_pkg:
  - WM_WRITE_FIRST and WM_READ_FIRST constants.
  - State encoding ST_CLEAR and ST_READY.
  - clog2 function.
- Sub-module bram_out_pipe: the READ_LATENCY-deep register chain for {dout, valid, err}. Instantiate one per port; coll_o is carried alongside port A's chain.
- The array, clear FSM and collision logic live in bram_dp_mem itself.

## Test plan
- Reset: hold rstb_n low, release it, DEPTH=16.
  - busy_o high for exactly 16 cycles.
  - Every read then returns INIT_WORD.
  - Requests issued during busy produce no valid.
- Byte write, WRITE_FIRST:
  - Word 3 holds 0x11223344. Port A writes 0xAABBCCDD to addra=0xC with wea=4'b0101.
  - douta = 0x11BB33DD, valida=1 after READ_LATENCY.
  - A later read returns 0x11BB33DD.
- READ_FIRST, READ_LATENCY=2:
  - Same write returns 0x11223344, two cycles later.
  - A next-cycle read returns 0x11BB33DD.
- Collision:
  - A writes 0x000000FF with wea=4'b0001; B writes 0x0000FF00 with web=4'b0011; same word, same edge.
  - Word becomes 0x0000FFFF; coll_o=1 for one cycle.
- Out of range: addrb = DEPTH*4.
  - doutb=0, errb=1, validb=1; memory unchanged.
- clear_i in READY:
  - Issued while port A reads: busy_o for DEPTH cycles, the read in the clear cycle is dropped, and all words read INIT_WORD afterwards.
  - rstb_n pulsed mid-sweep: the sweep restarts from word 0.
